// File: rtl/rtype_issue_stage.sv
// rtype_issue_stage: decode-and-operand-issue stage in front of the R-type ALU.
// It decodes funct7/funct3 into the ALU control code and reads operands from a
// 32x32 register file, with a bypass from the writeback port. A per-register
// pending scoreboard stalls any instruction that touches an unreturned result.
// The ALU sees the issued operands through a single output register.
module rtype_issue_stage #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] a,
  output logic [XLEN-1:0] b,
  output logic [2:0]      control,
  output logic [4:0]      rd,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            illegal
);

  localparam logic [6:0] OPC_RTYPE = 7'b0110011;

  localparam logic [2:0] CTL_ADD = 3'b000;
  localparam logic [2:0] CTL_SUB = 3'b001;
  localparam logic [2:0] CTL_AND = 3'b010;
  localparam logic [2:0] CTL_OR  = 3'b011;
  localparam logic [2:0] CTL_SLT = 3'b101;

  logic [XLEN-1:0] rf [NREG];
  logic [NREG-1:0] pending;
  logic [NREG-1:0] pending_nxt;
  logic [NREG-1:0] wb_mask;
  logic [NREG-1:0] pend_eff;

  logic [6:0]      opcode;
  logic [6:0]      funct7;
  logic [2:0]      funct3;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd_new;

  logic            legal;
  logic [2:0]      ctrl_dec;
  logic            wb_hit;
  logic            hz;
  logic            accept;
  logic            issue;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;

  assign opcode = instr[6:0];
  assign rd_new = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  // Decode the supported R-type encodings into an ALU control code.
  always_comb begin
    legal    = 1'b0;
    ctrl_dec = CTL_ADD;
    if (opcode == OPC_RTYPE) begin
      case ({funct7, funct3})
        {7'b0000000, 3'b000}: begin legal = 1'b1; ctrl_dec = CTL_ADD; end
        {7'b0100000, 3'b000}: begin legal = 1'b1; ctrl_dec = CTL_SUB; end
        {7'b0000000, 3'b111}: begin legal = 1'b1; ctrl_dec = CTL_AND; end
        {7'b0000000, 3'b110}: begin legal = 1'b1; ctrl_dec = CTL_OR;  end
        {7'b0000000, 3'b010}: begin legal = 1'b1; ctrl_dec = CTL_SLT; end
        default: begin legal = 1'b0; ctrl_dec = CTL_ADD; end
      endcase
    end
  end

  assign wb_hit = wb_en && (wb_rd != 5'd0);

  // Pending bits as seen this cycle: a same-cycle writeback already releases
  // its register, and register 0 never counts as pending.
  always_comb begin
    wb_mask = '0;
    if (wb_hit) begin
      wb_mask[wb_rd] = 1'b1;
    end
    pend_eff    = pending & ~wb_mask;
    pend_eff[0] = 1'b0;
  end

  // Illegal instructions never stall; they only need a free slot to be taken.
  assign hz = legal && (pend_eff[rs1] || pend_eff[rs2] || pend_eff[rd_new]);

  assign in_ready = (!out_valid || out_ready) && !hz;
  assign accept   = in_valid && in_ready;
  assign issue    = accept && legal;

  // Operand read with writeback bypass; register 0 is hard zero.
  always_comb begin
    op_a = rf[rs1];
    op_b = rf[rs2];
    if (wb_hit && (wb_rd == rs1)) begin
      op_a = wb_data;
    end
    if (wb_hit && (wb_rd == rs2)) begin
      op_b = wb_data;
    end
    if (rs1 == 5'd0) begin
      op_a = '0;
    end
    if (rs2 == 5'd0) begin
      op_b = '0;
    end
  end

  // Next scoreboard: writeback clears first, a new issue sets afterwards so
  // that a set/clear collision on the same register leaves it pending.
  always_comb begin
    pending_nxt = pending & ~wb_mask;
    if (issue && (rd_new != 5'd0)) begin
      pending_nxt[rd_new] = 1'b1;
    end
    pending_nxt[0] = 1'b0;
  end

  // Register file write port; register 0 is never written.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        rf[i] <= '0;
      end
    end else if (wb_hit) begin
      rf[wb_rd] <= wb_data;
    end
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

  // Output entry: load on issue, drop when consumed, otherwise hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      a         <= '0;
      b         <= '0;
      control   <= '0;
      rd        <= '0;
    end else if (issue) begin
      out_valid <= 1'b1;
      a         <= op_a;
      b         <= op_b;
      control   <= ctrl_dec;
      rd        <= rd_new;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // One-cycle flag for an accepted but unsupported instruction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      illegal <= 1'b0;
    end else begin
      illegal <= accept && !legal;
    end
  end

endmodule

// File: tb/tb_rtype_issue_stage.sv
// Bench for rtype_issue_stage: hand sequences, a decode vector table and a
// randomized run, all checked against a register/scoreboard model.
module tb_rtype_issue_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] instr = 32'h0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_rd = 5'd0;
  logic [31:0] wb_data = 32'h0;

  logic        in_ready;
  logic        out_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  control;
  logic [4:0]  rd;
  logic        illegal;

  rtype_issue_stage #(.XLEN(32), .NREG(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .a(a), .b(b), .control(control), .rd(rd),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  typedef struct packed {
    logic [6:0] f7;
    logic [2:0] f3;
    logic [2:0] ctrl;
  } enc_t;

  enc_t legal_tab [5];

  typedef struct packed {
    logic [31:0] ins;
    logic        exp_ill;
    logic [2:0]  exp_ctrl;
  } vec_t;

  vec_t vtab [10];

  // model state
  logic [31:0] m_rf [32];
  logic        m_pend [32];
  logic        m_ov;
  logic        m_ill;
  logic [31:0] m_a;
  logic [31:0] m_b;
  logic [2:0]  m_ctrl;
  logic [4:0]  m_rd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3,
                                     input logic [4:0] d, input logic [4:0] s1,
                                     input logic [4:0] s2, input logic [6:0] op);
    return {f7, s2, s1, f3, d, op};
  endfunction

  function automatic void decode(input logic [31:0] ins, output logic lg, output logic [2:0] c);
    lg = 1'b0;
    c  = 3'b000;
    if (ins[6:0] == 7'b0110011) begin
      for (int i = 0; i < 5; i++) begin
        if (legal_tab[i].f7 == ins[31:25] && legal_tab[i].f3 == ins[14:12]) begin
          lg = 1'b1;
          c  = legal_tab[i].ctrl;
        end
      end
    end
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_rf[i]   = 32'h0;
      m_pend[i] = 1'b0;
    end
    m_ov = 1'b0; m_ill = 1'b0; m_a = 32'h0; m_b = 32'h0; m_ctrl = 3'b0; m_rd = 5'd0;
  endtask

  function automatic logic stalls(input logic [4:0] r);
    return (r != 5'd0) && m_pend[r] && !(wb_en && wb_rd == r);
  endfunction

  function automatic logic [31:0] read_op(input logic [4:0] r);
    if (r == 5'd0) return 32'h0;
    if (wb_en && wb_rd == r) return wb_data;
    return m_rf[r];
  endfunction

  // Compare DUT against the model, then advance the model across the coming edge.
  task automatic step();
    logic lg, hz, er, acc;
    logic [2:0] c;
    logic [4:0] s1, s2, d;
    logic [31:0] na, nb;
    decode(instr, lg, c);
    s1 = instr[19:15];
    s2 = instr[24:20];
    d  = instr[11:7];
    chk("m_out_valid", {31'b0, out_valid}, {31'b0, m_ov});
    chk("m_illegal", {31'b0, illegal}, {31'b0, m_ill});
    if (m_ov) begin
      chk("m_a", a, m_a);
      chk("m_b", b, m_b);
      chk("m_control", {29'b0, control}, {29'b0, m_ctrl});
      chk("m_rd", {27'b0, rd}, {27'b0, m_rd});
    end
    hz = lg && (stalls(s1) || stalls(s2) || stalls(d));
    er = (!m_ov || out_ready) && !hz;
    chk("m_in_ready", {31'b0, in_ready}, {31'b0, er});
    if (!rst) begin
      model_reset();
      return;
    end
    acc = in_valid && er;
    na = read_op(s1);
    nb = read_op(s2);
    if (wb_en && wb_rd != 5'd0) begin
      m_rf[wb_rd]   = wb_data;
      m_pend[wb_rd] = 1'b0;
    end
    if (acc && lg) begin
      m_ov = 1'b1; m_a = na; m_b = nb; m_ctrl = c; m_rd = d;
      if (d != 5'd0) m_pend[d] = 1'b1;
    end else if (out_ready) begin
      m_ov = 1'b0;
    end
    m_ill = acc && !lg;
  endtask

  task automatic tick();
    @(negedge clk);
    step();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic [4:0] r, input logic [31:0] d);
    wb_en = 1'b1; wb_rd = r; wb_data = d;
    tick();
    wb_en = 1'b0;
  endtask

  initial begin
    legal_tab[0] = '{7'b0000000, 3'b000, 3'b000};
    legal_tab[1] = '{7'b0100000, 3'b000, 3'b001};
    legal_tab[2] = '{7'b0000000, 3'b111, 3'b010};
    legal_tab[3] = '{7'b0000000, 3'b110, 3'b011};
    legal_tab[4] = '{7'b0000000, 3'b010, 3'b101};

    vtab[0] = '{mk(7'b0000000, 3'b000, 5'd0, 5'd5, 5'd6, 7'h33), 1'b0, 3'b000};
    vtab[1] = '{mk(7'b0100000, 3'b000, 5'd0, 5'd5, 5'd6, 7'h33), 1'b0, 3'b001};
    vtab[2] = '{mk(7'b0000000, 3'b111, 5'd0, 5'd5, 5'd6, 7'h33), 1'b0, 3'b010};
    vtab[3] = '{mk(7'b0000000, 3'b110, 5'd0, 5'd5, 5'd6, 7'h33), 1'b0, 3'b011};
    vtab[4] = '{mk(7'b0000000, 3'b010, 5'd0, 5'd5, 5'd6, 7'h33), 1'b0, 3'b101};
    vtab[5] = '{mk(7'b0000001, 3'b000, 5'd0, 5'd5, 5'd6, 7'h33), 1'b1, 3'b000};
    vtab[6] = '{mk(7'b0000000, 3'b001, 5'd0, 5'd5, 5'd6, 7'h33), 1'b1, 3'b000};
    vtab[7] = '{mk(7'b0000000, 3'b100, 5'd0, 5'd5, 5'd6, 7'h33), 1'b1, 3'b000};
    vtab[8] = '{mk(7'b0100000, 3'b111, 5'd0, 5'd5, 5'd6, 7'h33), 1'b1, 3'b000};
    vtab[9] = '{mk(7'b0000000, 3'b000, 5'd0, 5'd5, 5'd6, 7'h13), 1'b1, 3'b000};

    model_reset();
    @(posedge clk); #1;
    tick();
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_a", a, 32'd0);
    chk("rst_illegal", {31'b0, illegal}, 32'd0);
    rst = 1'b1;

    // writeback then add x7,x5,x6
    out_ready = 1'b0;
    wb(5'd5, 32'd7);
    wb(5'd6, 32'd3);
    instr = 32'h006283B3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("add_valid", {31'b0, out_valid}, 32'd1);
    chk("add_a", a, 32'd7);
    chk("add_b", b, 32'd3);
    chk("add_ctrl", {29'b0, control}, 32'd0);
    chk("add_rd", {27'b0, rd}, 32'd7);

    // sub x8,x7,x5 stalls on x7 until writeback, then bypasses
    instr = 32'h40538433; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      chk("sub_stall", {31'b0, in_ready}, 32'd0);
      tick();
    end
    wb_en = 1'b1; wb_rd = 5'd7; wb_data = 32'd10;
    #1;
    chk("sub_bypass_ready", {31'b0, in_ready}, 32'd1);
    tick();
    wb_en = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("sub_a", a, 32'd10);
    chk("sub_b", b, 32'd7);
    chk("sub_ctrl", {29'b0, control}, 32'd1);
    chk("sub_rd", {27'b0, rd}, 32'd8);

    // backpressure hold, then consume + accept in one cycle
    instr = 32'h0062F4B3; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("hold_ready", {31'b0, in_ready}, 32'd0);
      tick();
      chk("hold_a", a, 32'd10);
      chk("hold_rd", {27'b0, rd}, 32'd8);
      chk("hold_ctrl", {29'b0, control}, 32'd1);
    end
    out_ready = 1'b1;
    #1;
    chk("release_ready", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("and_valid", {31'b0, out_valid}, 32'd1);
    chk("and_a", a, 32'd7);
    chk("and_b", b, 32'd3);
    chk("and_ctrl", {29'b0, control}, 32'd2);
    chk("and_rd", {27'b0, rd}, 32'd9);
    tick();

    // illegal div: one-cycle flag, no pending set on x7
    out_ready = 1'b0;
    instr = 32'h02A2C3B3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("div_illegal", {31'b0, illegal}, 32'd1);
    chk("div_out_valid", {31'b0, out_valid}, 32'd0);
    instr = 32'h00038533; in_valid = 1'b1;
    #1;
    chk("div_no_pending", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("div_pulse_end", {31'b0, illegal}, 32'd0);
    chk("after_div_a", a, 32'd10);

    // writeback to x0 is ignored
    out_ready = 1'b1;
    wb(5'd0, 32'hFFFFFFFF);
    instr = 32'h000060B3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("x0_a", a, 32'd0);
    chk("x0_b", b, 32'd0);
    chk("x0_ctrl", {29'b0, control}, 32'd3);
    chk("x0_rd", {27'b0, rd}, 32'd1);

    // back-to-back reload, then asynchronous reset mid-cycle
    out_ready = 1'b1; instr = 32'h006283B3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("b2b_rd", {27'b0, rd}, 32'd7);
    chk("b2b_valid", {31'b0, out_valid}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("arst_a", a, 32'd0);
    chk("arst_rd", {27'b0, rd}, 32'd0);
    chk("arst_in_ready", {31'b0, in_ready}, 32'd1);
    model_reset();
    tick();
    rst = 1'b1;
    instr = 32'h006283B3; in_valid = 1'b1;
    #1;
    chk("arst_no_pending", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("arst_rf_a", a, 32'd0);
    chk("arst_rf_b", b, 32'd0);

    // decode vector table
    out_ready = 1'b1;
    tick();
    wb(5'd5, 32'd7);
    wb(5'd6, 32'd3);
    for (int i = 0; i < 10; i++) begin
      instr = vtab[i].ins; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk($sformatf("vec%0d_illegal", i), {31'b0, illegal}, {31'b0, vtab[i].exp_ill});
      chk($sformatf("vec%0d_valid", i), {31'b0, out_valid}, {31'b0, !vtab[i].exp_ill});
      if (!vtab[i].exp_ill) begin
        chk($sformatf("vec%0d_ctrl", i), {29'b0, control}, {29'b0, vtab[i].exp_ctrl});
        chk($sformatf("vec%0d_a", i), a, 32'd7);
        chk($sformatf("vec%0d_b", i), b, 32'd3);
      end
      tick();
    end

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      int sel;
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) begin
        instr = $urandom;
      end else begin
        sel = $urandom_range(0, 4);
        instr = mk(legal_tab[sel].f7, legal_tab[sel].f3,
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 7'h33);
      end
      wb_en   = ($urandom_range(0, 1) != 0);
      wb_rd   = 5'($urandom_range(0, 7));
      wb_data = $urandom;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
